// File: rtl/testmasterslave13_peer_pkg.sv
// ---------------------------------------------------------------------------
// testmasterslave13_peer_types
//   Shared types and default constants for the TestMasterSlave13 peer agent.
//   - PeerPhases : transaction phases of the offer/response sequence
//   - DEFAULT_*  : default parameter values used by the top level
//   - sat_inc16  : saturating 16-bit increment for the response counter
// ---------------------------------------------------------------------------
package testmasterslave13_peer_types;

    localparam int          CNT_W            = 16;
    localparam int          DEFAULT_GAP      = 2;
    localparam int          DEFAULT_TIMEOUT  = 16;
    localparam logic [31:0] DEFAULT_OFFSET2  = 32'd100;
    localparam logic [31:0] DEFAULT_SEQ_INIT = 32'd0;

    typedef enum logic [1:0] {
        IDLE,
        OFFER_A,
        OFFER_B,
        WAIT_RESP
    } PeerPhases;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/testmasterslave13_peer_down_counter.sv
// ---------------------------------------------------------------------------
// peer_down_counter
//   Loadable down-counter that stops at zero and reports a zero flag.
//   Ports:
//     clk          - clock, rising edge
//     rst          - asynchronous active-high reset (count <= RST_VAL)
//     i_load       - load i_load_value this cycle (has priority over i_dec)
//     i_load_value - value to load
//     i_dec        - decrement by one if not already zero
//     o_zero       - count is zero (decoded from the register, no input path)
// ---------------------------------------------------------------------------
module peer_down_counter #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/testmasterslave13_peer.sv
// ---------------------------------------------------------------------------
// testmasterslave13_peer
//   Counterpart agent for the TestMasterSlave13 interface set. Offers a
//   sequence value on the two slave channels, waits for the DUT's notify
//   strobe on the master channel, and keeps response bookkeeping.
//
//   Optional build macro: PEER_SHARED_CHECK_EN
//     adds output err_shared (sticky: sh_in != m_in_data on an accepted
//     notify) and latches sh_in2 into a debug register at the same time.
//
//   Ports:
//     clk, rst        - clock (rising edge), asynchronous active-high reset
//     m_out_data      - value presented to DUT m_in (last response + 1)
//     m_in_data       - DUT m_out
//     m_in_notify     - DUT m_out_notify, one-cycle valid strobe
//     s_out/_sync     - first slave channel data / sync pulse
//     s_out2/_sync    - second slave channel data / sync (odd seq only)
//     sh_in, sh_in2   - DUT shared outputs (used only with the macro)
//     resp_count      - responses accepted, saturating at 16'hFFFF
//     last_resp       - last accepted m_in_data
//     err_timeout     - sticky flag: a WAIT_RESP timed out
//     err_shared      - (macro only) sticky shared-output mismatch flag
//
//   Every output is a flop. The channel outputs are loaded on the edge that
//   enters the phase they belong to, so s_out_sync is high exactly while the
//   FSM sits in OFFER_A and s_out2 changes on entry to OFFER_B.
// ---------------------------------------------------------------------------
module testmasterslave13_peer
    import testmasterslave13_peer_types::*;
#(
    parameter logic [31:0] SEQ_INIT = DEFAULT_SEQ_INIT,
    parameter logic [31:0] OFFSET2  = DEFAULT_OFFSET2,
    parameter int          GAP      = DEFAULT_GAP,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] m_out_data,
    input  logic [31:0] m_in_data,
    input  logic        m_in_notify,
    output logic [31:0] s_out,
    output logic        s_out_sync,
    output logic [31:0] s_out2,
    output logic        s_out2_sync,
    input  logic [31:0] sh_in,
    input  logic [31:0] sh_in2,
    output logic [15:0] resp_count,
    output logic [31:0] last_resp,
`ifdef PEER_SHARED_CHECK_EN
    output logic        err_shared,
`endif
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP);
    // The timeout counter runs TIMEOUT-1 .. 0, giving TIMEOUT wait cycles;
    // expiry is the wait cycle in which it already reads zero.
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);

    PeerPhases   r_state;
    PeerPhases   w_state_next;
    logic [31:0] r_seq;
    logic [31:0] w_seq_next;
    logic [31:0] w_s_out_next;
    logic        w_s_out_sync_next;
    logic [31:0] w_s_out2_next;
    logic        w_s_out2_sync_next;
    logic        w_accept;
    logic        w_expire;
    logic        w_gap_load;
    logic        w_gap_dec;
    logic        w_gap_zero;
    logic        w_to_load;
    logic        w_to_dec;
    logic        w_to_zero;

    peer_down_counter #(
        .WIDTH   (CNT_W),
        .RST_VAL (GAP_LOAD)
    ) u_gap_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_gap_load),
        .i_load_value (GAP_LOAD),
        .i_dec        (w_gap_dec),
        .o_zero       (w_gap_zero)
    );

    peer_down_counter #(
        .WIDTH   (CNT_W),
        .RST_VAL (TO_LOAD)
    ) u_timeout_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_to_load),
        .i_load_value (TO_LOAD),
        .i_dec        (w_to_dec),
        .o_zero       (w_to_zero)
    );

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next       = r_state;
        w_seq_next         = r_seq;
        w_s_out_next       = s_out;
        w_s_out_sync_next  = s_out_sync;
        w_s_out2_next      = s_out2;
        w_s_out2_sync_next = s_out2_sync;
        w_accept           = 1'b0;
        w_expire           = 1'b0;
        w_gap_load         = 1'b0;
        w_gap_dec          = 1'b0;
        w_to_load          = 1'b0;
        w_to_dec           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_gap_zero) begin
                    w_state_next      = OFFER_A;
                    w_s_out_next      = r_seq;
                    w_s_out_sync_next = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            OFFER_A: begin
                w_state_next       = OFFER_B;
                w_s_out_sync_next  = 1'b0;
                w_s_out2_next      = r_seq + OFFSET2;
                w_s_out2_sync_next = r_seq[0];
            end
            OFFER_B: begin
                w_state_next       = WAIT_RESP;
                w_s_out2_sync_next = 1'b0;
                w_to_load          = 1'b1;
            end
            WAIT_RESP: begin
                // Notify is checked first so it wins on the expiry cycle.
                if (m_in_notify) begin
                    w_accept     = 1'b1;
                    w_seq_next   = r_seq + 32'd1;
                    w_gap_load   = 1'b1;
                    w_state_next = IDLE;
                end else if (w_to_zero) begin
                    w_expire     = 1'b1;
                    w_seq_next   = r_seq + 32'd1;
                    w_gap_load   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seq       <= SEQ_INIT;
            s_out       <= '0;
            s_out_sync  <= 1'b0;
            s_out2      <= '0;
            s_out2_sync <= 1'b0;
            m_out_data  <= '0;
            last_resp   <= '0;
            resp_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_seq       <= w_seq_next;
            s_out       <= w_s_out_next;
            s_out_sync  <= w_s_out_sync_next;
            s_out2      <= w_s_out2_next;
            s_out2_sync <= w_s_out2_sync_next;
            if (w_accept) begin
                last_resp  <= m_in_data;
                m_out_data <= m_in_data + 32'd1;
                resp_count <= sat_inc16(resp_count);
            end
            if (w_expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef PEER_SHARED_CHECK_EN
    logic [31:0] r_dbg_sh2;
    logic        w_unused_dbg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_shared <= 1'b0;
            r_dbg_sh2  <= '0;
        end else if (w_accept) begin
            if (sh_in != m_in_data) begin
                err_shared <= 1'b1;
            end
            r_dbg_sh2 <= sh_in2;
        end
    end

    // Debug capture is only observed in simulation / on a probe.
    assign w_unused_dbg = ^r_dbg_sh2;
`else
    // Shared outputs are not observed in this build.
    logic w_unused_sh;
    assign w_unused_sh = ^{sh_in, sh_in2};
`endif

endmodule

// File: tb/tb_testmasterslave13_peer.sv
// ---------------------------------------------------------------------------
// tb_testmasterslave13_peer
//   Transaction-level bench for testmasterslave13_peer. The reference model
//   tracks only protocol facts: next sequence value, idle length before the
//   next offer, response bookkeeping and sticky error flags.
// ---------------------------------------------------------------------------
module tb_testmasterslave13_peer;

    localparam int          GAP      = 2;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] OFFSET2  = 32'd100;
    localparam logic [31:0] SEQ_INIT = 32'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_out_data;
    logic [31:0] m_in_data;
    logic        m_in_notify;
    logic [31:0] s_out;
    logic        s_out_sync;
    logic [31:0] s_out2;
    logic        s_out2_sync;
    logic [31:0] sh_in;
    logic [31:0] sh_in2;
    logic [15:0] resp_count;
    logic [31:0] last_resp;
    logic        err_timeout;
`ifdef PEER_SHARED_CHECK_EN
    logic        err_shared;
`endif

    testmasterslave13_peer #(
        .SEQ_INIT (SEQ_INIT),
        .OFFSET2  (OFFSET2),
        .GAP      (GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_out_data  (m_out_data),
        .m_in_data   (m_in_data),
        .m_in_notify (m_in_notify),
        .s_out       (s_out),
        .s_out_sync  (s_out_sync),
        .s_out2      (s_out2),
        .s_out2_sync (s_out2_sync),
        .sh_in       (sh_in),
        .sh_in2      (sh_in2),
        .resp_count  (resp_count),
        .last_resp   (last_resp),
`ifdef PEER_SHARED_CHECK_EN
        .err_shared  (err_shared),
`endif
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_seq;
    logic [31:0] m_last;
    logic [31:0] m_mout;
    int          m_count;
    bit          m_err;
    bit          m_err_sh;
    int          m_idle;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        m_seq    = SEQ_INIT;
        m_last   = '0;
        m_mout   = '0;
        m_count  = 0;
        m_err    = 1'b0;
        m_err_sh = 1'b0;
        m_idle   = GAP + 1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        m_in_notify = 1'b0;
        m_in_data   = '0;
        sh_in       = $urandom;
        sh_in2      = $urandom;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One offer/response transaction. d < TIMEOUT: notify in wait cycle d;
    // otherwise let it time out. noise drives ignored notify pulses outside
    // WAIT_RESP.
    task automatic do_txn(input int d, input logic [31:0] data,
                          input logic [31:0] sh, input bit noise);
        int waited;
        waited = 0;
        while (s_out_sync !== 1'b1 && waited < 64) begin
            m_in_notify = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            m_in_data   = $urandom;
            @(negedge clk);
            waited++;
        end
        m_in_notify = 1'b0;
        n_tests++;
        if (waited != m_idle) begin
            n_fail++;
            $display("FAIL idle_len: got %0d cycles, expected %0d", waited, m_idle);
        end
        n_tests++;
        if (s_out !== m_seq || s_out2_sync !== 1'b0) begin
            n_fail++;
            $display("FAIL offer_a: s_out=%0h s_out2_sync=%b, expected %0h/0", s_out, s_out2_sync, m_seq);
        end
        // Pulse during OFFER_A must be ignored
        m_in_notify = noise;
        m_in_data   = $urandom;
        @(negedge clk);
        m_in_notify = 1'b0;
        n_tests++;
        if (s_out_sync !== 1'b0 || s_out2 !== m_seq + OFFSET2 || s_out2_sync !== m_seq[0]) begin
            n_fail++;
            $display("FAIL offer_b: sync=%b s_out2=%0h sync2=%b, expected 0/%0h/%b",
                     s_out_sync, s_out2, s_out2_sync, m_seq + OFFSET2, m_seq[0]);
        end
        @(negedge clk);
        n_tests++;
        if (s_out2_sync !== 1'b0 || s_out !== m_seq || s_out2 !== m_seq + OFFSET2) begin
            n_fail++;
            $display("FAIL wait_hold: sync2=%b s_out=%0h s_out2=%0h, expected 0/%0h/%0h",
                     s_out2_sync, s_out, s_out2, m_seq, m_seq + OFFSET2);
        end
        if (d < TIMEOUT) begin
            repeat (d) @(negedge clk);
            m_in_notify = 1'b1;
            m_in_data   = data;
            sh_in       = sh;
            sh_in2      = $urandom;
            @(negedge clk);
            m_in_notify = 1'b0;
            m_last = data;
            m_mout = data + 32'd1;
            if (m_count < 65535) m_count++;
            if (sh != data) m_err_sh = 1'b1;
        end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            n_tests++;
            if (err_timeout !== m_err) begin
                n_fail++;
                $display("FAIL pre_expiry_err: got %b, expected %b", err_timeout, m_err);
            end
            @(negedge clk);
            m_err = 1'b1;
        end
        m_seq  = m_seq + 32'd1;
        m_idle = GAP + 1;
        n_tests++;
        if (last_resp !== m_last || m_out_data !== m_mout) begin
            n_fail++;
            $display("FAIL resp_data: last_resp=%0h m_out_data=%0h, expected %0h/%0h",
                     last_resp, m_out_data, m_last, m_mout);
        end
        n_tests++;
        if (resp_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL resp_count: got %0d, expected %0d", resp_count, m_count);
        end
        n_tests++;
        if (err_timeout !== m_err) begin
            n_fail++;
            $display("FAIL err_timeout: got %b, expected %b", err_timeout, m_err);
        end
`ifdef PEER_SHARED_CHECK_EN
        n_tests++;
        if (err_shared !== m_err_sh) begin
            n_fail++;
            $display("FAIL err_shared: got %b, expected %b", err_shared, m_err_sh);
        end
`endif
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        m_in_notify = 1'b0;
        m_in_data   = '0;
        sh_in       = '0;
        sh_in2      = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_out, s_out2, m_out_data, last_resp} !== '0 || resp_count !== '0 ||
            {s_out_sync, s_out2_sync, err_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: s_out=%0h s_out2=%0h mout=%0h last=%0h cnt=%0d flags=%b, expected all 0",
                     s_out, s_out2, m_out_data, last_resp, resp_count, {s_out_sync, s_out2_sync, err_timeout});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_response();
        do_txn(0, 32'd7, 32'd7, 1'b0);
        do_txn(4, 32'h1234_5678, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn(TIMEOUT, '0, '0, 1'b0);
        do_txn(3, 32'hCAFE, 32'hCAFE, 1'b0);
        n_tests++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b, expected 1", err_timeout);
        end
    endtask

    task automatic test_exact_expiry();
        apply_reset();
        do_txn(TIMEOUT - 1, 32'd42, 32'd42, 1'b0);
        n_tests++;
        if (err_timeout !== 1'b0 || resp_count !== 16'd1) begin
            n_fail++;
            $display("FAIL exact_expiry: err=%b cnt=%0d, expected 0/1", err_timeout, resp_count);
        end
    endtask

    task automatic test_reset_mid_offer();
        int k;
        do_txn(2, 32'd11, 32'd11, 1'b0);
        k = 0;
        while (s_out_sync !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (s_out_sync !== 1'b1) begin
            n_fail++;
            $display("FAIL offer_wait: s_out_sync=%b after %0d cycles, expected 1", s_out_sync, k);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (s_out_sync !== 1'b0 || resp_count !== '0 || s_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset: sync=%b cnt=%0d s_out=%0h, expected 0/0/0", s_out_sync, resp_count, s_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Notify in IDLE is ignored
        m_in_notify = 1'b1;
        m_in_data   = 32'd99;
        @(negedge clk);
        m_in_notify = 1'b0;
        m_idle      = GAP;
        n_tests++;
        if (resp_count !== '0 || last_resp !== '0) begin
            n_fail++;
            $display("FAIL idle_notify: cnt=%0d last=%0h, expected 0/0", resp_count, last_resp);
        end
        do_txn(1, 32'd20, 32'd20, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] data;
            logic [31:0] sh;
            data = $urandom;
            sh   = ($urandom_range(0, 3) == 0) ? $urandom : data;
            do_txn($urandom_range(0, TIMEOUT + 1), data, sh, 1'b1);
        end
    endtask

`ifdef PEER_SHARED_CHECK_EN
    task automatic test_shared();
        apply_reset();
        do_txn(0, 32'd5, 32'd5, 1'b0);
        n_tests++;
        if (err_shared !== 1'b0) begin
            n_fail++;
            $display("FAIL shared_match: got %b, expected 0", err_shared);
        end
        do_txn(0, 32'd9, 32'd3, 1'b0);
        n_tests++;
        if (err_shared !== 1'b1) begin
            n_fail++;
            $display("FAIL shared_mismatch: got %b, expected 1", err_shared);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_response();
        test_timeout();
        test_exact_expiry();
        test_reset_mid_offer();
        test_random();
`ifdef PEER_SHARED_CHECK_EN
        test_shared();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
